// File: rtl/cpu_step_ctrl.sv
// Run/step/burst clock-enable controller for a debug CPU, with a debounced
// step button, a divided run rate and a PC breakpoint that parks the core in HALT.
module cpu_step_ctrl #(
    parameter int CNT_W  = 32,
    parameter int DIV_W  = 16,
    parameter int DB_CYC = 4,
    parameter int LED_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic             step_btn,
    input  logic [7:0]       burst_len,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      halt_pc,
    input  logic             bp_en,
    output logic             cpu_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [LED_W-1:0] led,
    output logic [1:0]       dbg_state
);

    localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_db_level;
    logic             r_db_prev;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_rem;
    logic             r_cpu_en;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic             w_press;
    logic             w_bp_hit;
    logic             w_run_mode;
    logic             w_div_fire;
    logic [DIV_W-1:0] w_div_next;
    logic [7:0]       w_burst_len;

    // The debounced level only moves after DB_CYC consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_sync1   <= step_btn;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_press     = r_db_level & ~r_db_prev;
    assign w_bp_hit    = bp_en && (pc_in == halt_pc);
    assign w_run_mode  = (mode == 2'b01) || (mode == 2'b10);
    assign w_div_fire  = (mode == 2'b01) || (r_div == '0);
    assign w_div_next  = ((mode == 2'b10) && (r_div < div_val)) ? r_div + DIV_W'(1) : '0;
    assign w_burst_len = (burst_len == 8'd0) ? 8'd1 : burst_len;

    // Entry into RUN already issues the first enable, so IDLE and RUN share one decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_rem       <= '0;
            r_cpu_en    <= 1'b0;
            r_halted    <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(r_cpu_en);
            r_cpu_en    <= 1'b0;
            r_halted    <= 1'b0;
            unique case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_run_mode) begin
                        if (w_div_fire && w_bp_hit) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            r_div    <= '0;
                        end else begin
                            r_state  <= S_RUN;
                            r_cpu_en <= w_div_fire;
                            r_div    <= w_div_next;
                        end
                    end else if ((r_state == S_IDLE) && (mode == 2'b11) && w_press) begin
                        r_state <= S_BURST;
                        r_rem   <= w_burst_len;
                    end else begin
                        r_state <= S_IDLE;
                        r_div   <= '0;
                    end
                end
                S_BURST: begin
                    if (w_bp_hit) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_rem    <= '0;
                    end else begin
                        r_cpu_en <= 1'b1;
                        r_rem    <= r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    if (mode == 2'b00) begin
                        r_state <= S_IDLE;
                    end else if ((mode == 2'b11) && w_press) begin
                        r_state  <= S_IDLE;
                        r_cpu_en <= 1'b1;
                    end else begin
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_en    = r_cpu_en;
    assign halted    = r_halted;
    assign cycle_cnt = r_cycle_cnt;
    assign led       = r_cycle_cnt[LED_W-1:0];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: an edge-by-edge behavioural model checked every cycle,
// plus directed scenarios with hand-computed totals.
module tb_cpu_step_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] div_val = '0;
  logic        step_btn = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] halt_pc = '0;
  logic        bp_en = 1'b0;
  logic        cpu_en;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [15:0] led;
  logic [1:0]  dbg_state;

  int n_run = 0;
  int n_fail = 0;

  cpu_step_ctrl #(.CNT_W(32), .DIV_W(16), .DB_CYC(DB), .LED_W(16)) dut (
    .clk(clk), .reset(reset), .mode(mode), .div_val(div_val), .step_btn(step_btn),
    .burst_len(burst_len), .pc_in(pc_in), .halt_pc(halt_pc), .bp_en(bp_en),
    .cpu_en(cpu_en), .halted(halted), .cycle_cnt(cycle_cnt), .led(led), .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  typedef enum int {M_IDLE = 0, M_RUN = 1, M_BURST = 2, M_HALT = 3} mst_t;
  mst_t        m_state = M_IDLE;
  int          m_age = 0;
  int          m_rem = 0;
  bit          m_en = 1'b0;
  bit          m_halted = 1'b0;
  logic [31:0] m_cnt = '0;
  bit          m_lvl = 1'b0;
  bit          m_lvl_prev = 1'b0;
  bit          b_q[$];
  bit          s_q[$];

  task automatic model_reset();
    m_state = M_IDLE; m_age = 0; m_rem = 0; m_en = 0; m_halted = 0; m_cnt = '0;
    m_lvl = 0; m_lvl_prev = 0; b_q.delete(); s_q.delete();
  endtask

  task automatic model_step();
    bit press, s, flip, fire, hit, new_en;
    // button: two sample delay, then DB equal samples opposing the level flip it
    press = m_lvl && !m_lvl_prev;
    b_q.push_back(step_btn);
    s = (b_q.size() >= 3) ? b_q[b_q.size()-3] : 1'b0;
    s_q.push_back(s);
    flip = (s_q.size() >= DB);
    for (int i = 0; i < DB; i++)
      if (flip && s_q[s_q.size()-1-i] == m_lvl) flip = 0;
    m_lvl_prev = m_lvl;
    if (flip) m_lvl = !m_lvl;
    if (b_q.size() > 8) void'(b_q.pop_front());
    if (s_q.size() > DB + 2) void'(s_q.pop_front());

    m_cnt = m_cnt + 32'(m_en);
    new_en = 0;
    hit = bp_en && (pc_in == halt_pc);
    case (m_state)
      M_IDLE, M_RUN: begin
        if (mode == 2'b01 || mode == 2'b10) begin
          if (m_state == M_IDLE) m_age = 0;
          fire = (mode == 2'b01) || ((m_age % (int'(div_val) + 1)) == 0);
          if (fire && hit) m_state = M_HALT;
          else begin
            m_state = M_RUN;
            new_en = fire;
            m_age++;
          end
        end else if (m_state == M_IDLE && mode == 2'b11 && press) begin
          m_state = M_BURST;
          m_rem = (burst_len == 0) ? 1 : int'(burst_len);
        end else m_state = M_IDLE;
      end
      M_BURST: begin
        if (hit) m_state = M_HALT;
        else begin
          new_en = 1;
          m_rem--;
          if (m_rem == 0) m_state = M_IDLE;
        end
      end
      M_HALT: begin
        if (mode == 2'b00) m_state = M_IDLE;
        else if (mode == 2'b11 && press) begin
          new_en = 1;
          m_state = M_IDLE;
        end
      end
      default: m_state = M_IDLE;
    endcase
    m_en = new_en;
    m_halted = (m_state == M_HALT);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // scoreboard: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("cpu_en", 32'(cpu_en), 32'(m_en));
      check("halted", 32'(halted), 32'(m_halted));
      check("cycle_cnt", cycle_cnt, m_cnt);
      check("led", 32'(led), 32'(m_cnt[15:0]));
      check("state", 32'(dbg_state), 32'(int'(m_state)));
    end
  end

  // driver tasks
  int cyc_idx = 0;
  int en_q[$];
  bit cpu_like = 0;

  task automatic step_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc_idx++;
      if (cpu_en) begin
        en_q.push_back(cyc_idx);
        if (cpu_like) pc_in = pc_in + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; mode = 0; div_val = 0; step_btn = 0; burst_len = 0;
    pc_in = 0; halt_pc = 0; bp_en = 0; cpu_like = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    cyc_idx = 0;
    en_q.delete();
  endtask

  task automatic press(input int hold, input int after);
    step_btn = 1;
    step_cyc(hold);
    step_btn = 0;
    step_cyc(after);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    int seen;
    do_reset();
    check("reset_cpu_en", 32'(cpu_en), 0);
    check("reset_halted", 32'(halted), 0);
    check("reset_cycle_cnt", cycle_cnt, 0);
    check("reset_led", 32'(led), 0);

    // continuous run for 10 sampled cycles
    mode = 2'b01;
    step_cyc(1);
    check("run_first_en", 32'(cpu_en), 1);
    step_cyc(9);
    mode = 2'b00;
    step_cyc(1);
    check("run_en_count", en_q.size(), 10);
    check("run_en_off", 32'(cpu_en), 0);
    check("run_cycle_cnt", cycle_cnt, 10);
    check("run_led", 32'(led), 10);

    // divided run, period 4
    do_reset();
    div_val = 16'd3;
    mode = 2'b10;
    step_cyc(16);
    mode = 2'b00;
    step_cyc(1);
    check("div_en_count", en_q.size(), 4);
    for (int k = 0; k < en_q.size() && k < 4; k++)
      check("div_en_pos", en_q[k], 1 + 4 * k);
    check("div_cycle_cnt", cycle_cnt, 4);

    // bouncing then held button: one burst of 5
    do_reset();
    mode = 2'b11;
    burst_len = 8'd5;
    step_btn = 1; step_cyc(1);
    step_btn = 0; step_cyc(1);
    press(50, 12);
    check("burst_en_count", en_q.size(), 5);
    if (en_q.size() == 5) check("burst_contiguous", en_q[4] - en_q[0], 4);
    check("burst_cycle_cnt", cycle_cnt, 5);
    check("burst_idle", 32'(dbg_state), 0);

    // breakpoint at 0x10 while running
    do_reset();
    cpu_like = 1;
    bp_en = 1;
    halt_pc = 32'h10;
    mode = 2'b01;
    step_cyc(20);
    check("bp_en_count", en_q.size(), 4);
    check("bp_halted", 32'(halted), 1);
    check("bp_pc", pc_in, 32'h10);
    check("bp_cycle_cnt", cycle_cnt, 4);
    check("bp_state", 32'(dbg_state), 3);
    bp_en = 0; step_cyc(3);
    bp_en = 1; step_cyc(1);
    check("bp_toggle_halted", 32'(halted), 1);

    // single step out of HALT
    mode = 2'b11;
    step_cyc(3);
    check("halt_hold", 32'(halted), 1);
    en_q.delete();
    press(10, 10);
    check("halt_step_count", en_q.size(), 1);
    check("halt_step_halted", 32'(halted), 0);
    check("halt_step_state", 32'(dbg_state), 0);
    check("halt_step_cycle_cnt", cycle_cnt, 5);

    // reset two cycles into an 8-long burst
    do_reset();
    mode = 2'b11;
    burst_len = 8'd8;
    step_btn = 1;
    seen = 0;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      step_cyc(1);
      seen = en_q.size();
    end
    check("rst_burst_started", seen, 2);
    reset = 0;
    step_btn = 0;
    #1;
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    step_cyc(2);
    reset = 1;
    en_q.delete();
    step_cyc(20);
    check("rst_no_enable", en_q.size(), 0);
    press(10, 15);
    check("rst_new_burst", en_q.size(), 8);
    check("rst_new_cycle_cnt", cycle_cnt, 8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
